// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial transmitter for one byte per frame: start bit, eight data bits sent
// LSB first, an optional even-parity bit, then one stop bit. Each bit lasts
// CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit period (2..65535)
//   PARITY_EN     1 inserts an even-parity bit after the data, 0 omits it
//
// Ports
//   clk       system clock; all state changes on its rising edge
//   rst       asynchronous active-high reset
//   tx_start  request to send tx_data; honoured only while idle
//   tx_data   byte to send; captured when the request is accepted
//   tx        serial line output, registered, idle high
//   tx_busy   high while a frame is in progress
//   tx_done   one-cycle pulse in the first idle cycle after the stop bit
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    // A one-bit counter is still needed when CLKS_PER_BIT is 2, where
    // $clog2 would otherwise give the correct width of 1 anyway; the guard
    // only protects against degenerate parameter values.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             parity_bit;
    logic             parity_next;
    logic             tx_next;
    logic             done_next;
    logic             bit_end;

    // End of the current bit period. The counter never wraps; it is cleared
    // on every bit-state transition instead.
    assign bit_end = (bit_cnt == CNT_LAST);

    // Busy is a pure decode of the state, so reset clears it immediately.
    assign tx_busy = (state != IDLE);

    // State and datapath registers. The line output and the done pulse are
    // registered so tx changes exactly on the edge that changes the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= cnt_next;
            bit_idx    <= idx_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
            tx_done    <= done_next;
        end
    end

    // Next-state and datapath logic. Parity is captured at acceptance
    // because the shift register is consumed while the data bits go out.
    // The line level is derived from the next state and next shift value,
    // which keeps the registered tx aligned with the registered state.
    always_comb begin
        state_next  = state;
        cnt_next    = bit_cnt;
        idx_next    = bit_idx;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        done_next   = 1'b0;
        tx_next     = 1'b1;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    shift_next  = tx_data;
                    parity_next = ^tx_data;
                    cnt_next    = '0;
                    idx_next    = '0;
                    state_next  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    idx_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = STOP;
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx with CLKS_PER_BIT=4. One instance runs
// with parity enabled, a second with parity disabled. Expected line levels
// come from a frame built bit by bit from the byte being sent; a simple
// mid-bit sampling receiver recovers each byte and checks its parity.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CLKS = 4;

    logic       clk;
    logic       rst;
    logic       start_p;
    logic [7:0] data_p;
    logic       tx_p;
    logic       busy_p;
    logic       done_p;
    logic       start_n;
    logic [7:0] data_n;
    logic       tx_n;
    logic       busy_n;
    logic       done_n;

    int tests;
    int failed;

    uart_tx #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (start_p),
        .tx_data  (data_p),
        .tx       (tx_p),
        .tx_busy  (busy_p),
        .tx_done  (done_p)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS), .PARITY_EN(0)) dut_np (
        .clk      (clk),
        .rst      (rst),
        .tx_start (start_n),
        .tx_data  (data_n),
        .tx       (tx_n),
        .tx_busy  (busy_n),
        .tx_done  (done_n)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the request inputs of the selected instance.
    task automatic applyStimulus(input bit np, input logic start, input logic [7:0] data);
        if (np) begin
            start_n = start;
            data_n  = data;
        end else begin
            start_p = start;
            data_p  = data;
        end
    endtask

    // Single comparison point; every call counts as one test.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check line, busy and done of one instance against fixed values.
    task automatic checkLine(input string tag, input bit np, input logic t, input logic b, input logic d);
        checkOutput({tag, " tx"},   8'(np ? tx_n : tx_p),     8'(t));
        checkOutput({tag, " busy"}, 8'(np ? busy_n : busy_p), 8'(b));
        checkOutput({tag, " done"}, 8'(np ? done_n : done_p), 8'(d));
    endtask

    // Called at the first negedge after acceptance. Walks the whole frame
    // against the reference bit list while throwing random requests and data
    // at the busy transmitter, then checks the done cycle. On the last frame
    // cycle the request inputs are set to next_start/next_data so a
    // back-to-back request is presented during the done cycle.
    task automatic checkFrame(input string name, input logic [7:0] data, input bit np,
                              input logic next_start, input logic [7:0] next_data);
        logic exp_bits[$];
        logic rx_bits[$];
        logic [7:0] rx_byte;
        logic tx_o;
        int ncyc;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
        if (!np) exp_bits.push_back(($countones(data) % 2) == 1);
        exp_bits.push_back(1'b1);
        ncyc = exp_bits.size() * CLKS;
        for (int c = 0; c < ncyc; c++) begin
            tx_o = np ? tx_n : tx_p;
            checkOutput($sformatf("%s tx c%0d", name, c), 8'(tx_o), 8'(exp_bits[c / CLKS]));
            checkOutput($sformatf("%s busy c%0d", name, c), 8'(np ? busy_n : busy_p), 8'h01);
            checkOutput($sformatf("%s done c%0d", name, c), 8'(np ? done_n : done_p), 8'h00);
            if ((c % CLKS) == CLKS / 2) rx_bits.push_back(tx_o);
            if (c == ncyc - 1)
                applyStimulus(np, next_start, next_data);
            else
                applyStimulus(np, 1'($urandom_range(0, 1)), 8'($urandom));
            @(negedge clk);
        end
        checkLine({name, " donecyc"}, np, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) rx_byte[i] = rx_bits[i + 1];
        checkOutput({name, " rx start"}, 8'(rx_bits[0]), 8'h00);
        checkOutput({name, " rx byte"}, rx_byte, data);
        checkOutput({name, " rx stop"}, 8'(rx_bits[rx_bits.size() - 1]), 8'h01);
        if (!np)
            checkOutput({name, " rx parity err"}, 8'(($countones(rx_byte) + int'(rx_bits[9])) % 2), 8'h00);
    endtask

    // Confirm the transmitter stays idle (no queued second frame).
    task automatic idleCheck(input string name, input bit np, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkLine($sformatf("%s idle%0d", name, i), np, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] d;
        bit np;
        tests   = 0;
        failed  = 0;
        rst     = 1'b1;
        start_p = 1'b0;
        data_p  = 8'h00;
        start_n = 1'b0;
        data_n  = 8'h00;

        // Reset state, with a request held during reset that must be ignored.
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'hA5);
        @(negedge clk);
        @(negedge clk);
        checkLine("reset p", 0, 1'b1, 1'b0, 1'b0);
        checkLine("reset n", 1, 1'b1, 1'b0, 1'b0);

        // First request accepted on the first edge after release: A5.
        rst = 1'b0;
        @(negedge clk);
        checkFrame("A5", 8'hA5, 0, 1'b0, 8'h00);
        idleCheck("A5", 0, 3);

        // Odd and zero population bytes.
        applyStimulus(0, 1'b1, 8'h07);
        @(negedge clk);
        checkFrame("07", 8'h07, 0, 1'b0, 8'h00);
        idleCheck("07", 0, 1);
        applyStimulus(0, 1'b1, 8'h00);
        @(negedge clk);
        checkFrame("00", 8'h00, 0, 1'b0, 8'h00);
        idleCheck("00", 0, 1);

        // Back-to-back: request presented in the done cycle of the first.
        applyStimulus(0, 1'b1, 8'h3C);
        @(negedge clk);
        checkFrame("3C", 8'h3C, 0, 1'b1, 8'hC3);
        @(negedge clk);
        checkFrame("C3", 8'hC3, 0, 1'b0, 8'h00);
        idleCheck("C3", 0, 2);

        // No-parity instance with all ones.
        applyStimulus(1, 1'b1, 8'hFF);
        @(negedge clk);
        checkFrame("FF np", 8'hFF, 1, 1'b0, 8'h00);
        idleCheck("FF np", 1, 2);

        // Random bytes on randomly chosen instances.
        for (int k = 0; k < 6; k++) begin
            d  = 8'($urandom);
            np = 1'($urandom_range(0, 1));
            applyStimulus(np, 1'b1, d);
            @(negedge clk);
            checkFrame($sformatf("rnd%0d", k), d, np, 1'b0, 8'h00);
            idleCheck($sformatf("rnd%0d", k), np, 1);
        end

        // Reset in the middle of data bit 3 (frame cycles 16..19).
        applyStimulus(0, 1'b1, 8'hA5);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        checkLine("pre-rst", 0, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 checkLine("async rst", 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h96);
        @(negedge clk);
        checkLine("in rst", 0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkFrame("96 after rst", 8'h96, 0, 1'b0, 8'h00);
        idleCheck("96", 0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit period; legal range 2..65535.
REQ-002 SHALL provide parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit after the data bits and 0 omits it.
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port tx_start  input  1  request to send tx_data; sampled every clk edge.
REQ-006 SHALL provide port tx_data  input  8  byte to transmit; sampled only when a request is accepted.
REQ-007 SHALL provide port tx  output  1  serial line; idle high.
REQ-008 SHALL provide port tx_busy  output  1  high while a frame is in progress.
REQ-009 SHALL provide port tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE bit state holds for exactly CLKS_PER_BIT cycles, timed by an internal bit counter of width ceil(log2(CLKS_PER_BIT)).
REQ-011 SHALL accept a request when tx_start=1 in IDLE: on that edge, latch tx_data into an 8-bit shift register, clear the bit counter, and enter START.
REQ-012 SHALL ignore tx_start whenever the FSM is not in IDLE; no queuing, and the frame in progress is not disturbed.
REQ-013 SHALL ignore changes on tx_data after acceptance; the transmitted byte is the one latched in REQ-011.
REQ-014 SHALL drive tx registered: 1 in IDLE, 0 in START, shift-register bit 0 in DATA (LSB first), the parity bit in PARITY, 1 in STOP.
REQ-015 SHALL, in DATA, shift the register right by one and increment a 3-bit bit index at the end of each bit period; after bit index 7 completes, go to PARITY if PARITY_EN=1, else to STOP.
REQ-016 SHALL compute the parity bit as XOR of the 8 latched data bits, so that data plus parity holds an even number of ones.
REQ-017 SHALL go from PARITY to STOP after one bit period, and from STOP to IDLE after one bit period.
REQ-018 SHALL make tx go low on the first edge after acceptance, giving a latency of 1 cycle.
REQ-019 SHALL keep tx low for CLKS_PER_BIT cycles in START.
REQ-020 SHALL make the total frame length 11*CLKS_PER_BIT cycles when PARITY_EN=1 and 10*CLKS_PER_BIT cycles when PARITY_EN=0.
REQ-021 SHALL drive tx_busy high in every state except IDLE.
REQ-022 SHALL pulse tx_done high for exactly one cycle, the first IDLE cycle after STOP; tx_busy is 0 in that cycle.
REQ-023 SHALL accept a tx_start that is high in the same cycle as tx_done (back-to-back frames), giving no idle gap beyond that cycle.
REQ-024 SHALL keep the bit counter from wrapping: it compares against CLKS_PER_BIT-1 and clears on each bit-state transition.

Reset
REQ-025 SHALL, while rst=1, asynchronously force state=IDLE, tx=1, tx_busy=0, tx_done=0, and clear the shift register, bit index and bit counter, including when a frame is in progress.
REQ-026 SHALL ignore tx_start while rst=1; the first request is accepted on the first edge after rst deasserts.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-027 SHALL verify a single frame: tx_data=8'hA5, tx_start pulsed once, PARITY_EN=1 -> tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,0(parity),1; tx_busy high for 44 cycles; one tx_done pulse.
REQ-028 SHALL verify odd-ones data: tx_data=8'h07 -> parity bit 1; tx_data=8'h00 -> parity bit 0; an attached receiver-side parity check reports no error for either.
REQ-029 SHALL verify back-to-back frames: tx_start held high continuously with 8'h3C then 8'hC3 -> two contiguous 44-cycle frames separated by exactly one idle-high cycle.
REQ-030 SHALL verify busy rejection: tx_start pulsed at cycle 10 of a frame with a different tx_data -> current frame unchanged, no second frame sent, a single tx_done.
REQ-031 SHALL verify reset mid-frame: rst asserted during DATA bit 3 -> tx=1 and tx_busy=0 immediately (asynchronous); a new frame sent after release is correct.
REQ-032 SHALL verify no parity: PARITY_EN=0, tx_data=8'hFF -> 40-cycle frame with the stop bit directly after data bit 7.
